// File: rtl/cs_seq_pkg.sv
// Shared types and sizing helpers for the multi-cycle carry-select adder sequencer.
package cs_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seq_state_t;

  typedef struct packed {
    logic [31:0] nslice;
    logic [31:0] idx_w;
  } seq_dims_t;

  // Slice count and slice-counter width; the counter is never narrower than one bit.
  function automatic seq_dims_t calc_dims(input int width, input int slice);
    seq_dims_t d;
    int n;
    n = width / slice;
    d.nslice = 32'(n);
    d.idx_w  = (n <= 1) ? 32'd1 : 32'($clog2(n));
    return d;
  endfunction

endpackage

// File: rtl/cs_add_sequencer_cs_block.sv
// Carry-select adder slice: both carry-in outcomes are formed up front and sel picks one.
module CS_block #(
  parameter int sizeRCA = 4
) (
  input  logic [sizeRCA-1:0] A,
  input  logic [sizeRCA-1:0] B,
  input  logic               sel,
  output logic [sizeRCA-1:0] S,
  output logic               Cout
);

  logic [sizeRCA:0] sum_c0;
  logic [sizeRCA:0] sum_c1;

  assign sum_c0 = {1'b0, A} + {1'b0, B};
  assign sum_c1 = {1'b0, A} + {1'b0, B} + {{sizeRCA{1'b0}}, 1'b1};

  assign {Cout, S} = sel ? sum_c1 : sum_c0;

endmodule

// File: rtl/cs_add_sequencer.sv
// Sequences a WIDTH-bit add through one SLICE-bit carry-select slice, one slice per cycle.
// Optional macro CS_SEQ_SUB_EN adds the sub port for two's-complement subtraction.
module cs_add_sequencer
  import cs_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Carry_i,
`ifdef CS_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Carry_o
);

  localparam seq_dims_t DIMS = calc_dims(WIDTH, SLICE);
  localparam int NSLICE = int'(DIMS.nslice);
  localparam int IDX_W  = int'(DIMS.idx_w);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  generate
    if (WIDTH % SLICE != 0) begin : g_bad_width
      $error("cs_add_sequencer: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  seq_state_t state;
  seq_state_t state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] s_reg;
  logic             carry_reg;
  logic [IDX_W-1:0] idx;

  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic [SLICE-1:0] slice_s;
  logic             slice_c;

  logic [WIDTH-1:0] b_load;
  logic             carry_load;
  logic             accept;
  logic             last;

  // Subtraction is A + ~B + 1, so the slice hardware is shared unchanged.
`ifdef CS_SEQ_SUB_EN
  assign b_load     = sub ? ~B : B;
  assign carry_load = sub ? 1'b1 : Carry_i;
`else
  assign b_load     = B;
  assign carry_load = Carry_i;
`endif

  assign accept  = (state == IDLE) && in_valid;
  assign last    = (idx == LAST_IDX);
  assign slice_a = a_reg[int'(idx)*SLICE +: SLICE];
  assign slice_b = b_reg[int'(idx)*SLICE +: SLICE];

  CS_block #(
    .sizeRCA(SLICE)
  ) u_slice (
    .A   (slice_a),
    .B   (slice_b),
    .sel (carry_reg),
    .S   (slice_s),
    .Cout(slice_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Result and carry registers stay untouched outside RUN so DONE and IDLE hold the last sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      s_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
    end else if (accept) begin
      a_reg     <= A;
      b_reg     <= b_load;
      s_reg     <= '0;
      carry_reg <= carry_load;
      idx       <= '0;
    end else if (state == RUN) begin
      s_reg[int'(idx)*SLICE +: SLICE] <= slice_s;
      carry_reg                        <= slice_c;
      if (!last) begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign S       = s_reg;
  assign Carry_o = carry_reg;

endmodule

// File: tb/tb_cs_add_sequencer.sv
// Randomized and directed bench for cs_add_sequencer against a cycle-count transaction model.
module tb_cs_add_sequencer;

  localparam int WIDTH  = 32;
  localparam int SLICE  = 4;
  localparam int NSLICE = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Carry_i;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Carry_o;
`ifdef CS_SEQ_SUB_EN
  logic             sub;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cs_add_sequencer #(
    .WIDTH(WIDTH),
    .SLICE(SLICE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .Carry_i  (Carry_i),
`ifdef CS_SEQ_SUB_EN
    .sub      (sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .S        (S),
    .Carry_o  (Carry_o)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Transaction model: one operation in flight, result due NSLICE edges after acceptance.
  int unsigned      edges = 0;
  bit               pending = 1'b0;
  int unsigned      acc_edge = 0;
  logic [WIDTH-1:0] exp_s = '0;
  logic             exp_c = 1'b0;
  logic [WIDTH:0]   m_full;
  bit               m_sub;

  function automatic bit model_ov();
    return pending && (edges >= acc_edge + NSLICE);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pending = 1'b0;
    end else begin
      if (!pending && in_valid) begin
        m_sub = 1'b0;
`ifdef CS_SEQ_SUB_EN
        m_sub = sub;
`endif
        if (m_sub) m_full = {1'b0, A} + {1'b0, ~B} + 33'd1;
        else       m_full = {1'b0, A} + {1'b0, B} + {32'd0, Carry_i};
        exp_s    = m_full[WIDTH-1:0];
        exp_c    = m_full[WIDTH];
        pending  = 1'b1;
        acc_edge = edges + 1;
      end else if (model_ov() && out_ready) begin
        pending = 1'b0;
      end
      edges++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("in_ready", {63'd0, in_ready}, {63'd0, !pending});
      checkOutput("out_valid", {63'd0, out_valid}, {63'd0, model_ov()});
      if (model_ov()) begin
        checkOutput("S", 64'(S), 64'(exp_s));
        checkOutput("Carry_o", {63'd0, Carry_o}, {63'd0, exp_c});
      end
    end
  end

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
    int w;
    w = 0;
    while (in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) checkOutput("in_ready_timeout", 64'd0, 64'd1);
    A        = a;
    B        = b;
    Carry_i  = cin;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic waitResult(input string name, input logic [WIDTH-1:0] es, input logic ec);
    int cnt;
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput({name, "_latency"}, 64'(cnt), 64'(NSLICE));
    checkOutput({name, "_S"}, 64'(S), 64'(es));
    checkOutput({name, "_Carry_o"}, {63'd0, Carry_o}, {63'd0, ec});
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    Carry_i   = 1'b0;
`ifdef CS_SEQ_SUB_EN
    sub       = 1'b0;
`endif
    #2;
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_S", 64'(S), 64'd0);
    checkOutput("rst_Carry_o", {63'd0, Carry_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    waitResult("wrap", 32'h0000_0000, 1'b1);
    releaseResult();

    applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b1);
    waitResult("cin", 32'h2345_678A, 1'b0);
    releaseResult();

    // Backpressure with new operands offered the whole time DONE is stalled.
    applyStimulus(32'hDEAD_BEEF, 32'h0102_0304, 1'b0);
    waitResult("bp", 32'hDFAF_C1F3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      A        = $urandom;
      B        = $urandom;
      Carry_i  = 1'($urandom_range(0, 1));
      @(negedge clk);
      checkOutput("bp_hold_valid", {63'd0, out_valid}, 64'd1);
      checkOutput("bp_hold_ready", {63'd0, in_ready}, 64'd0);
      checkOutput("bp_hold_S", 64'(S), 64'(32'hDFAF_C1F3));
      checkOutput("bp_hold_C", {63'd0, Carry_o}, 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkOutput("bp_ready_after", {63'd0, in_ready}, 64'd1);
    checkOutput("bp_not_captured", 64'(S), 64'(32'hDFAF_C1F3));
    @(negedge clk);

    // Abort in RUN at idx=3 while the partial sum and carry are nonzero.
    applyStimulus(32'h0000_0FFF, 32'h0000_0FFF, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("abort_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("abort_S", 64'(S), 64'd0);
    checkOutput("abort_Carry_o", {63'd0, Carry_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (NSLICE + 2) @(negedge clk);
    applyStimulus(32'd2, 32'd3, 1'b0);
    waitResult("post_abort", 32'd5, 1'b0);
    releaseResult();

`ifdef CS_SEQ_SUB_EN
    sub = 1'b1;
    applyStimulus(32'd5, 32'd7, 1'b1);
    waitResult("sub_borrow", 32'hFFFF_FFFE, 1'b0);
    releaseResult();
    applyStimulus(32'd7, 32'd5, 1'b0);
    waitResult("sub_ok", 32'h0000_0002, 1'b1);
    releaseResult();
    sub = 1'b0;
`endif

    // Random traffic; the per-cycle compare process checks everything against the model.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      A         = ($urandom_range(0, 7) == 0) ? {WIDTH{1'b1}} : $urandom;
      B         = ($urandom_range(0, 7) == 0) ? {WIDTH{1'b1}} : $urandom;
      Carry_i   = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef CS_SEQ_SUB_EN
      sub       = 1'($urandom_range(0, 1));
`endif
      rst       = ($urandom_range(0, 249) == 0);
      @(negedge clk);
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (NSLICE + 4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cs_add_sequencer.md
# cs_add_sequencer

Multi-cycle adder controller for the FPU multiplier datapath. It adds two WIDTH-bit operands by passing them through one SLICE-bit carry-select slice over successive cycles. A registered carry drives the slice's select input from one cycle to the next. It trades latency for area in the wide final-sum stage and uses valid/ready handshakes on both sides.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be a multiple of SLICE
- SLICE, 4, bits processed per cycle (carry-select slice width)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- Carry_i  in  1  carry-in for the least significant slice
- sub  in  1  subtract request (present only with CS_SEQ_SUB_EN)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- S  out  WIDTH  sum
- Carry_o  out  1  carry-out of the most significant slice

## Operation
- NSLICE = WIDTH/SLICE. The slice counter idx is $clog2(NSLICE) bits wide, minimum 1.
- FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch A into a_reg, B into b_reg, Carry_i into carry_reg; set idx=0; clear S; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle the slice gets a_reg[idx*SLICE +: SLICE], b_reg[idx*SLICE +: SLICE] and sel=carry_reg.
  - The slice sum is written to S[idx*SLICE +: SLICE]. The slice carry is written to carry_reg.
  - idx increments each cycle. When idx==NSLICE-1, the last slice is written and the FSM goes to DONE.
- DONE:
  - out_valid=1, Carry_o=carry_reg.
  - S and Carry_o are held stable while out_ready=0.
  - On out_ready: go to IDLE.
- in_valid while not in IDLE is ignored; no operands are captured.
- Result is A+B+Carry_i modulo 2^WIDTH. Carry_o is bit WIDTH of the full sum.
- NSLICE=1 is legal: RUN lasts one cycle.
- Reset mid-operation aborts immediately:
  - The FSM returns to IDLE.
  - The result is discarded and out_valid is never asserted for the aborted operation.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, S=0, Carry_o=0, idx=0, carry_reg=0.
- Operands accepted at edge k → out_valid=1 after edge k+NSLICE.
- Result accepted at edge m → IDLE after edge m, so in_ready=1 in cycle m+1.
- Minimum initiation interval is NSLICE+2 cycles. The block never accepts new operands in the same cycle a result is handed off.
- in_ready and out_valid are decoded from registered state only. No combinational path from in_valid or out_ready to any output.
- S and Carry_o are registered. In IDLE they keep the last result until the next accept clears S.

## Configuration
- CS_SEQ_SUB_EN defined:
  - Port sub exists.
  - When sub=1 at accept, b_reg is loaded with ~B, carry_reg is loaded with 1, and Carry_i is ignored.
  - The result is A-B, and Carry_o=1 means no borrow (A>=B).
- CS_SEQ_SUB_EN undefined:
  - Port sub is absent.
  - b_reg is loaded with B and carry_reg with Carry_i.

## Structure
- Package cs_seq_pkg holds:
  - the state enum typedef (IDLE, RUN, DONE)
  - a function computing NSLICE and the counter width from WIDTH and SLICE
- One sub-module instance: the existing carry-select slice CS_block with sizeRCA=SLICE, fed by the idx-selected operand bits with sel=carry_reg.
- All sequencing lives in cs_add_sequencer.
- Elaboration-time assertion that WIDTH%SLICE==0.

## Test plan
- Reset: assert rst mid-cycle (asynchronous) → in_ready=1, out_valid=0, S=0, Carry_o=0 with no clock edge.
- WIDTH=32, SLICE=4: A=0x0000_0001, B=0xFFFF_FFFF, Carry_i=0 → out_valid exactly 8 cycles after accept, S=0x0000_0000, Carry_o=1.
- A=0x1234_5678, B=0x1111_1111, Carry_i=1 → S=0x2345_678A, Carry_o=0.
- Backpressure: out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands → S/Carry_o/out_valid stable, in_ready=0, new operands not captured. After out_ready=1, in_ready=1 the next cycle.
- Reset asserted in RUN at idx=3 → FSM returns to IDLE, out_valid stays 0, and the next operation A=2, B=3 gives S=5.
- With CS_SEQ_SUB_EN:
  - A=5, B=7, sub=1 → S=0xFFFF_FFFE, Carry_o=0.
  - A=7, B=5, sub=1 → S=0x0000_0002, Carry_o=1.
